// File: rtl/rv32_issue_scoreboard.sv
// RV32 issue scoreboard: per-register writeback countdown with hazard detection at ID.
// Build macro RV32_FORWARDING_EN: only a load-use on the newest issued load stalls.

module rv32_sb_entry #(
  parameter logic [1:0] LAT = 2'd3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_adv,
  input  logic       i_set,
  input  logic       i_set_ld,
  output logic [1:0] o_cnt,
  output logic       o_ld
);
  logic [1:0] r_cnt;
  logic       r_ld;

  // A new writer overrides the decrement; the load flag dies with the count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_ld  <= 1'b0;
    end else if (i_adv) begin
      if (i_set) begin
        r_cnt <= LAT;
        r_ld  <= i_set_ld;
      end else if (r_cnt != 2'd0) begin
        r_cnt <= r_cnt - 2'd1;
        if (r_cnt == 2'd1) r_ld <= 1'b0;
      end
    end
  end

  assign o_cnt = r_cnt;
  assign o_ld  = r_ld;
endmodule

module rv32_issue_scoreboard #(
  parameter int WB_LATENCY = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1,
  input  logic [4:0]  i_id_rs2,
  input  logic [1:0]  i_id_use_rs,
  input  logic [4:0]  i_id_rd,
  input  logic        i_id_register_wb,
  input  logic        i_id_is_load,
  input  logic        i_ex_ready,
  input  logic        i_flush,
  output logic        o_id_ready,
  output logic        o_issue,
  output logic [1:0]  o_hazard_rs,
  output logic [31:0] o_pending
);
  localparam logic [1:0] LAT = WB_LATENCY[1:0];

  logic [31:0][1:0] w_cnt;
  logic [31:0]      w_ld;
  logic [1:0]       w_stall;
  logic             w_issue;

  assign w_cnt[0] = 2'd0;
  assign w_ld[0]  = 1'b0;

  genvar r;
  generate
    for (r = 1; r < 32; r++) begin : g_ent
      rv32_sb_entry #(.LAT(LAT)) u_ent (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_adv    (i_ex_ready),
        .i_set    (w_issue & i_id_register_wb & (i_id_rd == 5'(r))),
        .i_set_ld (i_id_is_load),
        .o_cnt    (w_cnt[r]),
        .o_ld     (w_ld[r])
      );
    end
  endgenerate

`ifdef RV32_FORWARDING_EN
  // Only the load issued on the previous advance is still out of forwarding reach.
  assign w_stall[0] = w_ld[i_id_rs1] & (w_cnt[i_id_rs1] == LAT);
  assign w_stall[1] = w_ld[i_id_rs2] & (w_cnt[i_id_rs2] == LAT);
`else
  logic w_unused_ld;
  assign w_unused_ld = ^w_ld;
  assign w_stall[0]  = (w_cnt[i_id_rs1] != 2'd0);
  assign w_stall[1]  = (w_cnt[i_id_rs2] != 2'd0);
`endif

  assign o_hazard_rs[0] = i_id_valid & i_id_use_rs[0] & (i_id_rs1 != 5'd0) & w_stall[0];
  assign o_hazard_rs[1] = i_id_valid & i_id_use_rs[1] & (i_id_rs2 != 5'd0) & w_stall[1];
  assign o_id_ready     = i_ex_ready & ~|o_hazard_rs;
  assign w_issue        = i_id_valid & o_id_ready & ~i_flush & ~i_rst;
  assign o_issue        = w_issue;

  always_comb begin
    o_pending = '0;
    for (int i = 1; i < 32; i++) o_pending[i] = |w_cnt[i];
  end
endmodule

// File: tb/tb_rv32_issue_scoreboard.sv
// Directed bench for rv32_issue_scoreboard (WB_LATENCY=3), stall lengths follow the build macro.

module tb_rv32_issue_scoreboard;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [1:0]  id_use_rs = '0;
  logic        id_register_wb = 1'b0, id_is_load = 1'b0;
  logic        ex_ready = 1'b1, flush = 1'b0;
  logic        id_ready, issue;
  logic [1:0]  hazard_rs;
  logic [31:0] pending;

  int n_chk = 0;
  int n_err = 0;

`ifdef RV32_FORWARDING_EN
  localparam int N_ALU = 0;
  localparam int N_LD  = 1;
`else
  localparam int N_ALU = 3;
  localparam int N_LD  = 3;
`endif

  rv32_issue_scoreboard #(.WB_LATENCY(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs(id_use_rs),
    .i_id_rd(id_rd), .i_id_register_wb(id_register_wb), .i_id_is_load(id_is_load),
    .i_ex_ready(ex_ready), .i_flush(flush),
    .o_id_ready(id_ready), .o_issue(issue), .o_hazard_rs(hazard_rs), .o_pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [1:0] use_rs, input logic [4:0] rd, input logic wb,
                     input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs = use_rs;
    id_rd = rd; id_register_wb = wb; id_is_load = ld;
  endtask

  task automatic idle;
    drv(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  // Consumer of x5 in ID: expect n stall cycles with pend shown, then issue.
  task automatic stall_then_issue(input string tag, input int n, input logic [31:0] pend);
    for (int k = 0; k < n; k++) begin
      settle;
      chk({tag, "_hz"}, 32'(hazard_rs), 32'h1);
      chk({tag, "_rdy"}, 32'(id_ready), 32'h0);
      chk({tag, "_pend"}, pending, pend);
      tick;
    end
    settle;
    chk({tag, "_go_rdy"}, 32'(id_ready), 32'h1);
    chk({tag, "_go_iss"}, 32'(issue), 32'h1);
  endtask

  initial begin
    // Reset with a valid writer present: nothing may issue.
    drv(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0);
    settle;
    chk("rst_issue", 32'(issue), 32'h0);
    tick; tick;
    chk("rst_pend", pending, 32'h0);
    rst = 1'b0;
    idle;
    settle;
    chk("rst_hz", 32'(hazard_rs), 32'h0);
    tick;

    // ALU producer x5 -> consumer add x6,x5,x1
    drv(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b0);
    settle;
    chk("alu_issue", 32'(issue), 32'h1);
    tick;
    drv(1'b1, 5'd5, 5'd1, 2'b11, 5'd6, 1'b1, 1'b0);
    stall_then_issue("alu_use", N_ALU, 32'h20);
    tick;
    idle;
    settle;
    chk("alu_x6_pend", pending[6], 1'b1);
    tick; tick; tick;
    chk("alu_drain", pending, 32'h0);

    // Load producer x5 -> consumer add x6,x5,x0
    drv(1'b1, 5'd1, 5'd0, 2'b01, 5'd5, 1'b1, 1'b1);
    tick;
    drv(1'b1, 5'd5, 5'd0, 2'b11, 5'd6, 1'b1, 1'b0);
    stall_then_issue("ld_use", N_LD, 32'h20);
    tick;
    idle;
    tick; tick; tick;
    chk("ld_drain", pending, 32'h0);

    // x0 writes and non-reading instructions never stall on pending x5
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    tick;
    drv(1'b1, 5'd5, 5'd5, 2'b00, 5'd0, 1'b1, 1'b0);
    settle;
    chk("nouse_hz", 32'(hazard_rs), 32'h0);
    chk("nouse_iss", 32'(issue), 32'h1);
    tick;
    chk("x0_pend", pending, 32'h20);
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b0, 1'b0);
    settle;
    chk("nowb_iss", 32'(issue), 32'h1);
    tick;
    chk("nowb_pend", pending, 32'h20);
    idle;
    tick;
    chk("x0_drain", pending, 32'h0);

    // ex_ready low holds the load count; the stall length resumes unchanged
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b1);
    tick;
    drv(1'b1, 5'd7, 5'd0, 2'b01, 5'd8, 1'b1, 1'b0);
    ex_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      settle;
      chk("hold_iss", 32'(issue), 32'h0);
      chk("hold_hz", 32'(hazard_rs), 32'h1);
      tick;
      chk("hold_pend", pending, 32'h80);
    end
    ex_ready = 1'b1;
    id_rs1 = 5'd7;
    for (int k = 0; k < N_LD; k++) begin
      settle;
      chk("resume_rdy", 32'(id_ready), 32'h0);
      tick;
    end
    settle;
    chk("resume_iss", 32'(issue), 32'h1);
    tick;
    idle;
    tick; tick; tick;
    chk("hold_drain", pending, 32'h0);

    // WAW: addi x5 then lw x5 reloads the count to 3; flush blocks a clean issue
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0);
    tick;
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
    settle;
    chk("waw_iss", 32'(issue), 32'h1);
    tick;
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b0);
    flush = 1'b1;
    settle;
    chk("flush_iss", 32'(issue), 32'h0);
    chk("flush_rdy", 32'(id_ready), 32'h1);
    tick;
    flush = 1'b0;
    idle;
    chk("flush_pend", pending, 32'h20);
    tick;
    chk("waw_pend", pending, 32'h20);
    tick;
    chk("waw_drain", pending, 32'h0);

    // Reset during a load-use stall releases the waiting consumer
    drv(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
    tick;
    drv(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
    settle;
    chk("rs_stall_rdy", 32'(id_ready), 32'h0);
    chk("rs_stall_pend", pending, 32'h20);
    rst = 1'b1;
    settle;
    chk("rs_iss_in_rst", 32'(issue), 32'h0);
    tick;
    rst = 1'b0;
    chk("rs_pend0", pending, 32'h0);
    settle;
    chk("rs_hz0", 32'(hazard_rs), 32'h0);
    chk("rs_issue", 32'(issue), 32'h1);
    tick;
    idle;
    chk("rs_x6_pend", pending, 32'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
